tiny_alu_core: RTL and testbench

Multi-cycle ALU core driven by the command-side bus functional model: it accepts one command per start handshake, executes arithmetic, logic and 16-word scratch-memory operations, and returns a 64-bit result with error code and flag. It is the design under test directly downstream of the stimulus interface. Single-cycle, 4-cycle and iterative 33-cycle operations share one result/done path.

---
 rtl/tiny_alu_core.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tiny_alu_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_alu_core.sv
// tiny_alu_core: multi-cycle ALU with a 16 x 32 scratch memory.
// One command per start handshake; single-cycle, 4-cycle multiply and
// 33-cycle restoring divide share a registered result/done path.
module tiny_alu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sv,
  input  logic        op_prefix,
  input  logic [7:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        done,
  output logic        gp,
  output logic [63:0] result,
  output logic [7:0]  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE,
    S_HOLD
  } state_t;

  state_t      state_q;
  logic        sv_q;
  logic        pfx_q;
  logic [7:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] mem_q [16];
  logic [31:0] last_q;
  logic [1:0]  mcnt_q;
  logic [4:0]  dcnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        qneg_q;
  logic        rneg_q;
  logic        done_q;
  logic        gp_q;
  logic [63:0] result_q;
  logic [7:0]  err_q;

  logic        accept;
  logic [3:0]  aidx;
  logic [3:0]  bidx;
  logic        a_oob;
  logic        b_oob;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] mem_a;
  logic [31:0] mem_b;
  logic [63:0] mul_res;
  logic [63:0] exec_res;
  logic [7:0]  exec_err;
  logic        go_mul;
  logic        go_div;
  logic        wa_en;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        fin_en;
  logic [63:0] res_d;
  logic [7:0]  err_d;

  // A held start is taken on the HOLD exit edge, two edges after done rises,
  // so the driver has one full cycle to present fresh operands.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_HOLD));

  assign aidx    = a_q[3:0];
  assign bidx    = b_q[3:0];
  assign a_oob   = |a_q[31:4];
  assign b_oob   = |b_q[31:4];
  assign a_ext   = sv_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign b_ext   = sv_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign mem_a   = mem_q[aidx];
  assign mem_b   = mem_q[bidx];
  // Low 64 bits of the product of extended operands are exact for both modes.
  assign mul_res = a_ext * b_ext;

  // Decode the latched command into a single-cycle result or a multi-cycle start.
  always_comb begin
    exec_res = '0;
    exec_err = '0;
    go_mul   = 1'b0;
    go_div   = 1'b0;
    wa_en    = 1'b0;
    wa_data  = '0;
    wb_en    = 1'b0;
    wb_data  = '0;
    if (!pfx_q) begin
      case (op_q)
        8'd0: exec_res = '0;
        8'd1: exec_res = a_ext + b_ext;
        8'd2: exec_res = {32'b0, a_q & b_q};
        8'd3: exec_res = {32'b0, a_q ^ b_q};
        8'd4: go_mul = 1'b1;
        8'd5: begin
          if (b_q == '0) begin
            exec_err = 8'd1;
            exec_res = '1;
          end else begin
            go_div = 1'b1;
          end
        end
        8'd6: begin
          if (a_oob) exec_err = 8'd3;
          else exec_res = sv_q ? {{32{mem_a[31]}}, mem_a} : {32'b0, mem_a};
        end
        8'd7: begin
          if (a_oob) exec_err = 8'd3;
          else begin
            wa_en   = 1'b1;
            wa_data = b_q;
          end
        end
        8'd8: begin
          if (a_oob || b_oob) exec_err = 8'd3;
          else begin
            wa_en   = 1'b1;
            wa_data = mem_b;
          end
        end
        8'd9: begin
          if (a_oob || b_oob) exec_err = 8'd3;
          else begin
            exec_res = {mem_a, mem_b};
            wa_en    = 1'b1;
            wa_data  = mem_b;
            wb_en    = 1'b1;
            wb_data  = mem_a;
          end
        end
        8'd10: begin
          if (a_oob) exec_err = 8'd3;
          else begin
            wa_en   = 1'b1;
            wa_data = last_q;
          end
        end
        default: exec_err = 8'd2;
      endcase
    end else begin
      case (op_q)
        8'd1:    exec_res = a_ext - b_ext;
        8'd2:    exec_res = {32'b0, a_q | b_q};
        8'd3:    exec_res = {32'b0, ~(a_q ^ b_q)};
        default: exec_err = 8'd2;
      endcase
    end
  end

  // One restoring-divide step on magnitudes, plus sign fix-up of the final step.
  always_comb begin
    trial    = {rem_q, quo_q[31]};
    trial_ge = (trial >= {1'b0, dvs_q});
    rem_nx   = trial_ge ? (trial[31:0] - dvs_q) : trial[31:0];
    quo_nx   = {quo_q[30:0], trial_ge};
    q_fin    = qneg_q ? (-quo_nx) : quo_nx;
    r_fin    = rneg_q ? (-rem_nx) : rem_nx;
  end

  // Select the completing result for whichever path finishes this cycle.
  always_comb begin
    fin_en = 1'b0;
    res_d  = '0;
    err_d  = '0;
    case (state_q)
      S_EXEC: begin
        if (!go_mul && !go_div) begin
          fin_en = 1'b1;
          res_d  = exec_res;
          err_d  = exec_err;
        end
      end
      S_MUL: begin
        if (mcnt_q == 2'd2) begin
          fin_en = 1'b1;
          res_d  = mul_res;
        end
      end
      S_DIV: begin
        if (dcnt_q == 5'd31) begin
          fin_en = 1'b1;
          res_d  = {r_fin, q_fin};
        end
      end
      default: fin_en = 1'b0;
    endcase
  end

  // Command FSM, iteration counters, divider, memory and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sv_q     <= 1'b0;
      pfx_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= '0;
      mcnt_q   <= '0;
      dcnt_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      gp_q     <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
      for (int unsigned i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        sv_q  <= sv;
        pfx_q <= op_prefix;
        op_q  <= op;
        a_q   <= A;
        b_q   <= B;
      end

      case (state_q)
        S_IDLE: if (accept) state_q <= S_EXEC;
        S_EXEC: begin
          mcnt_q <= '0;
          dcnt_q <= '0;
          if (go_mul) begin
            state_q <= S_MUL;
          end else if (go_div) begin
            quo_q   <= (sv_q && a_q[31]) ? (-a_q) : a_q;
            dvs_q   <= (sv_q && b_q[31]) ? (-b_q) : b_q;
            rem_q   <= '0;
            qneg_q  <= sv_q && (a_q[31] ^ b_q[31]);
            rneg_q  <= sv_q && a_q[31];
            state_q <= S_DIV;
          end else begin
            state_q <= S_DONE;
          end
          if (wa_en) mem_q[aidx] <= wa_data;
          if (wb_en) mem_q[bidx] <= wb_data;
        end
        S_MUL: begin
          mcnt_q <= mcnt_q + 2'd1;
          if (fin_en) state_q <= S_DONE;
        end
        S_DIV: begin
          quo_q  <= quo_nx;
          rem_q  <= rem_nx;
          dcnt_q <= dcnt_q + 5'd1;
          if (fin_en) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_HOLD;
        S_HOLD: state_q <= accept ? S_EXEC : S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      done_q <= fin_en;
      if (fin_en) begin
        result_q <= res_d;
        err_q    <= err_d;
        gp_q     <= !res_d[63] && (res_d != '0);
        if (err_d == '0) last_q <= res_d[31:0];
      end
    end
  end

  assign done   = done_q;
  assign gp     = gp_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_tiny_alu_core.sv
// Self-checking bench for tiny_alu_core: directed commands with literal
// expectations, plus a cycle-by-cycle comparison against a behavioural model.
module tb_tiny_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sv;
  logic        op_prefix;
  logic [7:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        done;
  logic        gp;
  logic [63:0] result;
  logic [7:0]  err;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  tiny_alu_core dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sv        (sv),
    .op_prefix (op_prefix),
    .op        (op),
    .A         (A),
    .B         (B),
    .done      (done),
    .gp        (gp),
    .result    (result),
    .err       (err)
  );

  // Behavioural model: command semantics in plain arithmetic, timing as a
  // latency countdown followed by a two-edge cool-down before the next accept.
  logic [31:0] mm [16];
  logic [31:0] m_last;
  logic [63:0] m_res;
  logic [7:0]  m_err;
  logic        m_done;
  logic        m_gp;
  int          m_cnt;
  int          m_cool;
  logic        m_sv;
  logic        m_pfx;
  logic [7:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;

  function automatic longint ext(input logic s, input logic [31:0] v);
    return s ? longint'($signed(v)) : longint'({32'b0, v});
  endfunction

  function automatic int latency(input logic p, input logic [7:0] o, input logic [31:0] b);
    if (!p && o == 8'd4) return 4;
    if (!p && o == 8'd5 && b != 32'd0) return 33;
    return 1;
  endfunction

  task automatic model_finish();
    longint x, y, q, rm;
    logic [63:0] r;
    logic [7:0]  e;
    logic [31:0] t;
    logic        oa, ob;
    int          ia, ib;
    x  = ext(m_sv, m_a);
    y  = ext(m_sv, m_b);
    r  = '0;
    e  = '0;
    ia = int'(m_a[3:0]);
    ib = int'(m_b[3:0]);
    oa = (m_a > 32'd15);
    ob = (m_b > 32'd15);
    if (!m_pfx) begin
      case (m_op)
        8'd0: r = '0;
        8'd1: r = x + y;
        8'd2: r = {32'b0, m_a & m_b};
        8'd3: r = {32'b0, m_a ^ m_b};
        8'd4: r = x * y;
        8'd5: begin
          if (m_b == 32'd0) begin e = 8'd1; r = '1; end
          else begin q = x / y; rm = x % y; r = {rm[31:0], q[31:0]}; end
        end
        8'd6:  if (oa) e = 8'd3; else r = ext(m_sv, mm[ia]);
        8'd7:  if (oa) e = 8'd3; else mm[ia] = m_b;
        8'd8:  if (oa || ob) e = 8'd3; else mm[ia] = mm[ib];
        8'd9: begin
          if (oa || ob) e = 8'd3;
          else begin r = {mm[ia], mm[ib]}; t = mm[ia]; mm[ia] = mm[ib]; mm[ib] = t; end
        end
        8'd10: if (oa) e = 8'd3; else mm[ia] = m_last;
        default: e = 8'd2;
      endcase
    end else begin
      case (m_op)
        8'd1:    r = x - y;
        8'd2:    r = {32'b0, m_a | m_b};
        8'd3:    r = {32'b0, ~(m_a ^ m_b)};
        default: e = 8'd2;
      endcase
    end
    if (e == 8'd0) m_last = r[31:0];
    m_res  = r;
    m_err  = e;
    m_gp   = (r != 64'd0) && !r[63];
    m_done = 1'b1;
    m_cool = 2;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mm[i] = '0;
      m_last = '0; m_res = '0; m_err = '0; m_done = 1'b0; m_gp = 1'b0;
      m_cnt = 0; m_cool = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) model_finish();
      end else begin
        if (m_cool != 0) m_cool = m_cool - 1;
        if (m_cool == 0 && start) begin
          m_sv = sv; m_pfx = op_prefix; m_op = op; m_a = A; m_b = B;
          m_cnt = latency(op_prefix, op, B);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Issue one command starting at a negedge; check latency, result and err.
  task automatic run(input string nm, input logic s, input logic p, input logic [7:0] o,
                     input logic [31:0] a, input logic [31:0] b, input int lat,
                     input logic [63:0] er, input logic [7:0] ee, input logic hold);
    int n;
    sv = s; op_prefix = p; op = o; A = a; B = b; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 80);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, n);
    end else begin
      chk({nm, " latency"}, 64'(n - 1), 64'(lat));
      chk({nm, " result"}, result, er);
      chk({nm, " err"}, {56'b0, err}, {56'b0, ee});
    end
    if (!hold) start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; sv = 1'b0; op_prefix = 1'b0; op = '0; A = '0; B = '0;

    fork
      forever begin
        @(posedge clk);
        #3;
        if (cmp_en) begin
          checks++;
          if ({done, err, gp, result} !== {m_done, m_err, m_gp, m_res}) begin
            errors++;
            $display("FAIL cycle-compare t=%0t dut done=%b err=%0d gp=%b result=%h model done=%b err=%0d gp=%b result=%h",
                     $time, done, err, gp, result, m_done, m_err, m_gp, m_res);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset err", {56'b0, err}, 64'd0);
    chk("reset gp", {63'b0, gp}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run("add unsigned", 1'b0, 1'b0, 8'd1, 32'hFFFF_FFFF, 32'd1, 1, 64'h1_0000_0000, 8'd0, 1'b0);
    chk("add unsigned gp", {63'b0, gp}, 64'd1);
    run("add signed", 1'b1, 1'b0, 8'd1, 32'hFFFF_FFFF, 32'd1, 1, 64'd0, 8'd0, 1'b0);
    chk("add signed gp", {63'b0, gp}, 64'd0);
    run("mul signed", 1'b1, 1'b0, 8'd4, 32'hFFFF_FFFD, 32'd7, 4, 64'hFFFF_FFFF_FFFF_FFEB, 8'd0, 1'b0);
    run("div signed", 1'b1, 1'b0, 8'd5, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 8'd0, 1'b0);
    run("div unsigned", 1'b0, 1'b0, 8'd5, 32'd100, 32'd7, 33, 64'h0000_0002_0000_000E, 8'd0, 1'b0);
    run("div min/-1", 1'b1, 1'b0, 8'd5, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, 8'd0, 1'b0);
    run("div by zero", 1'b0, 1'b0, 8'd5, 32'd9, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0);
    run("illegal op 11", 1'b0, 1'b0, 8'd11, 32'd1, 32'd2, 1, 64'd0, 8'd2, 1'b0);
    run("illegal pfx op 4", 1'b0, 1'b1, 8'd4, 32'd1, 32'd2, 1, 64'd0, 8'd2, 1'b0);
    run("sub signed", 1'b1, 1'b1, 8'd1, 32'd5, 32'd9, 1, 64'hFFFF_FFFF_FFFF_FFFC, 8'd0, 1'b0);

    run("sta 3", 1'b0, 1'b0, 8'd7, 32'd3, 32'hDEAD_BEEF, 1, 64'd0, 8'd0, 1'b0);
    run("sta 4", 1'b0, 1'b0, 8'd7, 32'd4, 32'd5, 1, 64'd0, 8'd0, 1'b0);
    run("swp 3,4", 1'b0, 1'b0, 8'd9, 32'd3, 32'd4, 1, 64'hDEAD_BEEF_0000_0005, 8'd0, 1'b0);
    run("lda 4", 1'b0, 1'b0, 8'd6, 32'd4, 32'd0, 1, 64'h0000_0000_DEAD_BEEF, 8'd0, 1'b0);
    run("sta 16", 1'b0, 1'b0, 8'd7, 32'd16, 32'h1234_5678, 1, 64'd0, 8'd3, 1'b0);
    run("wmr 5", 1'b0, 1'b0, 8'd10, 32'd5, 32'd0, 1, 64'd0, 8'd0, 1'b0);
    run("lda 5 signed", 1'b1, 1'b0, 8'd6, 32'd5, 32'd0, 1, 64'hFFFF_FFFF_DEAD_BEEF, 8'd0, 1'b0);
    run("lda 0", 1'b0, 1'b0, 8'd6, 32'd0, 32'd0, 1, 64'd0, 8'd0, 1'b0);
    run("mov 6<-3", 1'b0, 1'b0, 8'd8, 32'd6, 32'd3, 1, 64'd0, 8'd0, 1'b0);
    run("lda 6", 1'b0, 1'b0, 8'd6, 32'd6, 32'd0, 1, 64'd5, 8'd0, 1'b0);
    run("mov B oob", 1'b0, 1'b0, 8'd8, 32'd6, 32'h20, 1, 64'd0, 8'd3, 1'b0);

    run("held and", 1'b0, 1'b0, 8'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 64'h0000_0000_F000_F000, 8'd0, 1'b1);
    run("held xor", 1'b0, 1'b0, 8'd3, 32'h1234_5678, 32'hFFFF_0000, 1, 64'h0000_0000_EDCB_5678, 8'd0, 1'b1);
    run("held or", 1'b0, 1'b1, 8'd2, 32'h0F0F_0000, 32'h0000_F0F0, 1, 64'h0000_0000_0F0F_F0F0, 8'd0, 1'b0);
    run("xnor", 1'b0, 1'b1, 8'd3, 32'hFFFF_0000, 32'hFF00_FF00, 1, 64'h0000_0000_FF00_00FF, 8'd0, 1'b0);

    sv = 1'b1; op_prefix = 1'b0; op = 8'd5; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort done", {63'b0, done}, 64'd0);
    chk("abort result", result, 64'd0);
    chk("abort err", {56'b0, err}, 64'd0);
    chk("abort gp", {63'b0, gp}, 64'd0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no done", 64'(seen), 64'd0);
    run("lda 4 after reset", 1'b0, 1'b0, 8'd6, 32'd4, 32'd0, 1, 64'd0, 8'd0, 1'b0);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
